// File: rtl/pattern_serializer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_serializer
// Purpose  : Accepts a parallel frame through a valid/ready load port and
//            shifts it out MSB-first, one bit per accepted serial transfer.
//            While shifting it tracks occurrences of the sequence 110 and
//            builds a per-bit match map plus a match count for the frame.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            load_valid/load_ready - frame request handshake
//            load_data, load_len   - payload and length (0 or >WIDTH -> WIDTH)
//            ser_bit/ser_valid/ser_ready - serial output handshake
//            bit_idx               - position of ser_bit in the frame
//            match_pulse           - current bit completes 110
//            done                  - one-cycle pulse after the last transfer
//            match_map/match_count - frame result, stable until next load
// Revision : 1.0 - initial release
// ============================================================================
module pattern_serializer #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [IDX_W-1:0] load_len,
    output logic             ser_bit,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic [IDX_W-1:0] bit_idx,
    output logic             match_pulse,
    output logic             done,
    output logic [WIDTH-1:0] match_map,
    output logic [IDX_W-1:0] match_count
);

    localparam logic [IDX_W-1:0] c_width = IDX_W'(WIDTH);
    localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic [IDX_W-1:0] len_q,    len_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [1:0]       hist_q,   hist_d;
    logic [WIDTH-1:0] map_q,    map_d;
    logic [IDX_W-1:0] count_q,  count_d;

    logic [IDX_W-1:0] w_len_clamp;
    logic [IDX_W-1:0] w_pos;
    logic             w_ser_bit;
    logic             w_match;

    // Frame lengths of zero or beyond the payload width mean "full width".
    assign w_len_clamp = ((load_len == '0) || (load_len > c_width)) ? c_width : load_len;

    // The payload is left-aligned on load so the next bit to send is always
    // the MSB of data_q; zeros shift in behind it, which keeps ser_bit at 0
    // whenever no frame is in flight.
    assign w_ser_bit = data_q[WIDTH-1];

    // Match-map position for the bit currently presented.
    assign w_pos   = len_q - idx_q - IDX_W'(1);
    assign w_match = (hist_q == 2'b11) && !w_ser_bit;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        idx_d   = idx_q;
        hist_d  = hist_q;
        map_d   = map_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    data_d  = load_data << (c_width - w_len_clamp);
                    len_d   = w_len_clamp;
                    idx_d   = '0;
                    hist_d  = 2'b00;
                    map_d   = '0;
                    count_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ser_ready) begin
                    data_d = {data_q[WIDTH-2:0], 1'b0};
                    hist_d = {hist_q[0], w_ser_bit};
                    if (w_match) begin
                        map_d   = map_q | (c_one << w_pos);
                        count_d = count_q + IDX_W'(1);
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == (len_q - IDX_W'(1))) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            hist_q  <= 2'b00;
            map_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            hist_q  <= hist_d;
            map_q   <= map_d;
            count_q <= count_d;
        end
    end

    // Handshake outputs decode directly from the state register.
    assign load_ready  = (state_q == IDLE);
    assign ser_valid   = (state_q == SEND);
    assign done        = (state_q == DONE);
    assign ser_bit     = w_ser_bit;
    assign bit_idx     = idx_q;
    assign match_pulse = ser_valid && w_match;
    assign match_map   = map_q;
    assign match_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_serializer
// Purpose  : Self-checking bench for pattern_serializer. A frame-level model
//            predicts every serial transfer and the frame result; a monitor
//            compares them against the DUT as transfers and done pulses occur.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_serializer;

    localparam int W = 16;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [W-1:0]  load_data;
    logic [IW-1:0] load_len;
    logic          ser_bit;
    logic          ser_valid;
    logic          ser_ready;
    logic [IW-1:0] bit_idx;
    logic          match_pulse;
    logic          done;
    logic [W-1:0]  match_map;
    logic [IW-1:0] match_count;

    pattern_serializer #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_len(load_len),
        .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_ready(ser_ready),
        .bit_idx(bit_idx), .match_pulse(match_pulse), .done(done),
        .match_map(match_map), .match_count(match_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        int   idx;
        logic p;
        bit   last;
    } bit_t;

    typedef struct {
        logic [W-1:0] map;
        int           cnt;
    } res_t;

    bit_t exp_bits[$];
    res_t exp_res[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: list the emitted bits, then mark every position
    // where the last three emitted bits read 1,1,0.
    task automatic push_model(input logic [W-1:0] d, input int l);
        int   n;
        logic bits[$];
        res_t r;
        bit_t e;
        n = (l == 0 || l > W) ? W : l;
        for (int k = 0; k < n; k++) bits.push_back(d[n-1-k]);
        r.map = '0;
        r.cnt = 0;
        for (int k = 0; k < n; k++) begin
            e.b    = bits[k];
            e.idx  = k;
            e.p    = (k >= 2) && bits[k-2] && bits[k-1] && !bits[k];
            e.last = (k == n - 1);
            if (e.p) begin
                r.map[n-1-k] = 1'b1;
                r.cnt++;
            end
            exp_bits.push_back(e);
        end
        exp_res.push_back(r);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    bit done_due = 0;
    initial begin
        bit_t e;
        res_t r;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_bits.delete();
                exp_res.delete();
                done_due = 0;
            end else begin
                if (done_due) begin
                    chk("done_after_last", {31'b0, done}, 32'd1);
                    done_due = 0;
                end else if (done) begin
                    chk("unexpected_done", {31'b0, done}, 32'd0);
                end
                if (done) begin
                    if (exp_res.size() == 0) begin
                        chk("result_queue_empty", 32'd0, 32'd1);
                    end else begin
                        r = exp_res.pop_front();
                        chk("match_map", 32'(match_map), 32'(r.map));
                        chk("match_count", 32'(match_count), 32'(r.cnt));
                    end
                end
                if (ser_valid && ser_ready) begin
                    if (exp_bits.size() == 0) begin
                        chk("unexpected_transfer", 32'd0, 32'd1);
                    end else begin
                        e = exp_bits.pop_front();
                        chk("ser_bit", {31'b0, ser_bit}, {31'b0, e.b});
                        chk("bit_idx", 32'(bit_idx), 32'(e.idx));
                        chk("match_pulse", {31'b0, match_pulse}, {31'b0, e.p});
                        if (e.last) done_due = 1;
                    end
                end
            end
        end
    end

    function automatic logic pick_ready(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc - 1) % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Runs one frame starting from an idle DUT at a drive point (#1 after an
    // active edge). Optionally checks the result against fixed constants.
    task automatic run_frame(input logic [W-1:0] d, input logic [IW-1:0] l,
                             input int mode, input bit hold_valid,
                             input bit chk_const, input logic [W-1:0] c_map,
                             input int c_cnt);
        int cyc;
        int n;
        n = (l == 0 || l > W) ? W : int'(l);
        chk("load_ready_idle", {31'b0, load_ready}, 32'd1);
        push_model(d, int'(l));
        load_valid = 1'b1;
        load_data  = d;
        load_len   = l;
        @(posedge clk); #1;
        load_valid = hold_valid;
        if (hold_valid) begin
            load_data = ~d;
            load_len  = 5'd5;
        end
        chk("first_bit_valid", {31'b0, ser_valid}, 32'd1);
        chk("load_ready_busy", {31'b0, load_ready}, 32'd0);
        cyc = 1;
        ser_ready = pick_ready(mode, cyc);
        while (!done && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            ser_ready = pick_ready(mode, cyc);
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        if (mode == 0) chk("done_latency", 32'(cyc), 32'(n + 1));
        load_valid = 1'b0;
        if (chk_const) begin
            chk("const_map", 32'(match_map), 32'(c_map));
            chk("const_count", 32'(match_count), 32'(c_cnt));
        end
        @(posedge clk); #1;
        chk("load_ready_return", {31'b0, load_ready}, 32'd1);
        if (chk_const) begin
            chk("stable_map", 32'(match_map), 32'(c_map));
            chk("stable_count", 32'(match_count), 32'(c_cnt));
        end
    endtask

    task automatic reset_mid_frame();
        int cyc;
        chk("load_ready_idle", {31'b0, load_ready}, 32'd1);
        push_model(16'hB6DB, 16);
        load_valid = 1'b1;
        load_data  = 16'hB6DB;
        load_len   = 5'd16;
        ser_ready  = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        cyc = 0;
        while (!(ser_valid && bit_idx == 5'd5) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_idx5", {31'b0, ser_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_ser_valid", {31'b0, ser_valid}, 32'd0);
        chk("rst_load_ready", {31'b0, load_ready}, 32'd1);
        chk("rst_match_count", 32'(match_count), 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_bit_idx", 32'(bit_idx), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", {31'b0, done}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        ser_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_load_ready", {31'b0, load_ready}, 32'd1);
        chk("reset_ser_valid", {31'b0, ser_valid}, 32'd0);
        chk("reset_ser_bit", {31'b0, ser_bit}, 32'd0);
        chk("reset_bit_idx", 32'(bit_idx), 32'd0);
        chk("reset_match_pulse", {31'b0, match_pulse}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_match_map", 32'(match_map), 32'd0);
        chk("reset_match_count", 32'(match_count), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reference frame, periodic frame, back-pressure.
        run_frame(16'h75C6, 5'd15, 0, 1'b0, 1'b1, 16'h0821, 3);
        run_frame(16'h6DB6, 5'd0, 0, 1'b0, 1'b1, 16'h1249, 5);
        run_frame(16'hFFFE, 5'd16, 1, 1'b0, 1'b1, 16'h0001, 1);
        // Short frames: no match may span the two.
        run_frame(16'h0003, 5'd2, 0, 1'b1, 1'b1, 16'h0000, 0);
        run_frame(16'h0000, 5'd1, 0, 1'b0, 1'b1, 16'h0000, 0);
        // Abort mid-frame, then a normal frame.
        reset_mid_frame();
        run_frame(16'h75C6, 5'd15, 0, 1'b0, 1'b1, 16'h0821, 3);

        for (int i = 0; i < 30; i++) begin
            run_frame(W'($urandom), IW'($urandom_range(0, 31)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      1'b0, '0, 0);
        end

        repeat (3) @(posedge clk);
        chk("bits_drained", 32'(exp_bits.size()), 32'd0);
        chk("results_drained", 32'(exp_res.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
